// File: rtl/eu_operand_fetch_if.sv
// rtl/eu_operand_fetch_if.sv - operand types and Y-buffer request/response interface
//
// Purpose:
//   eu_operand_fetch_pkg holds the local-address and data types shared by the
//   execution unit. eu_operand_fetch_if groups the two Y-buffer read ports.
//
// Ports (signals, seen from the requester / master modport):
//   op0_req_addr_o, op0_req_addr_valid_o   out  port 0 read request
//   op1_req_addr_o, op1_req_addr_valid_o   out  port 1 read request
//   op0_data_i, op0_data_success_i         in   port 0 read response (1 cycle later)
//   op1_data_i, op1_data_success_i         in   port 1 read response (1 cycle later)

package eu_operand_fetch_pkg;
  typedef logic [7:0]  type_alu_local_addr;
  typedef logic [31:0] type_exec_unit_data;
endpackage

interface eu_operand_fetch_if;
  import eu_operand_fetch_pkg::*;

  type_alu_local_addr op0_req_addr_o;
  logic               op0_req_addr_valid_o;
  type_alu_local_addr op1_req_addr_o;
  logic               op1_req_addr_valid_o;
  type_exec_unit_data op0_data_i;
  logic               op0_data_success_i;
  type_exec_unit_data op1_data_i;
  logic               op1_data_success_i;

  modport master (
    output op0_req_addr_o, op0_req_addr_valid_o,
    output op1_req_addr_o, op1_req_addr_valid_o,
    input  op0_data_i, op0_data_success_i,
    input  op1_data_i, op1_data_success_i
  );

  modport slave (
    input  op0_req_addr_o, op0_req_addr_valid_o,
    input  op1_req_addr_o, op1_req_addr_valid_o,
    output op0_data_i, op0_data_success_i,
    output op1_data_i, op1_data_success_i
  );
endinterface

// File: rtl/eu_operand_fetch.sv
// rtl/eu_operand_fetch.sv - Y-buffer operand fetch requester for the execution unit
//
// Purpose:
//   Accepts one decoded instruction with up to two local operand addresses,
//   reads the used operands from the Y-buffer (retrying every cycle until a
//   read succeeds) and hands the operand pair plus destination to the ALU.
//   Optional macro EU_FETCH_PORT_SWAP_EN: a failed operand is moved to the
//   opposite Y-buffer port (other bank) when that port is free.
//
// Ports:
//   clk, reset_n (sync, active-low), flush_i        control
//   instr_valid_i / instr_ready_o, instr_op*_i, instr_dest_addr_i   instruction in
//   ybuf (eu_operand_fetch_if.master)               Y-buffer read ports 0/1
//   alu_valid_o / alu_ready_i, alu_op0_o, alu_op1_o, alu_dest_addr_o  ALU out
//   fetch_timeout_o                                 one-cycle pulse at retry limit

module eu_operand_fetch
  import eu_operand_fetch_pkg::*;
#(
  parameter int MAX_RETRY = 15,
  parameter int CNT_BITS  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush_i,
  input  logic                instr_valid_i,
  output logic                instr_ready_o,
  input  type_alu_local_addr  instr_op0_addr_i,
  input  type_alu_local_addr  instr_op1_addr_i,
  input  logic                instr_op0_used_i,
  input  logic                instr_op1_used_i,
  input  type_alu_local_addr  instr_dest_addr_i,
  eu_operand_fetch_if.master  ybuf,
  output logic                alu_valid_o,
  input  logic                alu_ready_i,
  output type_exec_unit_data  alu_op0_o,
  output type_exec_unit_data  alu_op1_o,
  output type_alu_local_addr  alu_dest_addr_o,
  output logic                fetch_timeout_o
);

  localparam logic [CNT_BITS-1:0] RETRY_LIMIT = CNT_BITS'(MAX_RETRY);
  localparam logic [CNT_BITS-1:0] RETRY_LAST  = CNT_BITS'(MAX_RETRY - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;
  state_t state_q, state_d;

  type_alu_local_addr  op0_addr_q, op1_addr_q, dest_q;
  type_exec_unit_data  data0_q, data1_q;
  logic                need0_q, need1_q;
  // pendN_q: port N issued a request last cycle; portN_op_q: which operand it carried
  logic                pend0_q, pend1_q, port0_op_q, port1_op_q;
  // selN_q: operand N currently uses the opposite port
  logic                sel0_q, sel1_q, sel0_d, sel1_d;
  logic [CNT_BITS-1:0] cnt_q;
  logic                timeout_q;

  logic                accept, fetching, fetch_done;
  logic                hit_p0, hit_p1, cap0, cap1;
  type_exec_unit_data  cap0_data, cap1_data;
  logic                need0_left, need1_left;
  logic                p0_for_op0, p0_for_op1, p1_for_op0, p1_for_op1;
  logic                req0_v, req1_v;

  // Response routing: a success only counts against the operand recorded
  // for that port in the previous cycle, and only while it is still needed.
  always_comb begin
    fetching   = (state_q == S_FETCH);
    hit_p0     = pend0_q & ybuf.op0_data_success_i;
    hit_p1     = pend1_q & ybuf.op1_data_success_i;
    cap0       = fetching & need0_q & ((hit_p0 & ~port0_op_q) | (hit_p1 & ~port1_op_q));
    cap1       = fetching & need1_q & ((hit_p0 &  port0_op_q) | (hit_p1 &  port1_op_q));
    cap0_data  = (hit_p0 & ~port0_op_q) ? ybuf.op0_data_i : ybuf.op1_data_i;
    cap1_data  = (hit_p1 &  port1_op_q) ? ybuf.op1_data_i : ybuf.op0_data_i;
    need0_left = need0_q & ~cap0;
    need1_left = need1_q & ~cap1;
    fetch_done = fetching & ~need0_left & ~need1_left;

    // An operand captured this cycle is not re-requested this cycle.
    p0_for_op0 = need0_left & ~sel0_q;
    p0_for_op1 = need1_left &  sel1_q;
    p1_for_op0 = need0_left &  sel0_q;
    p1_for_op1 = need1_left & ~sel1_q;
    req0_v     = fetching & (p0_for_op0 | p0_for_op1);
    req1_v     = fetching & (p1_for_op0 | p1_for_op1);
  end

  assign ybuf.op0_req_addr_valid_o = req0_v;
  assign ybuf.op1_req_addr_valid_o = req1_v;
  assign ybuf.op0_req_addr_o       = p0_for_op1 ? op1_addr_q : op0_addr_q;
  assign ybuf.op1_req_addr_o       = p1_for_op0 ? op0_addr_q : op1_addr_q;

`ifdef EU_FETCH_PORT_SWAP_EN
  logic fail0_p0, fail0_p1, fail1_p0, fail1_p1;

  // Move a failed operand to the port opposite the one that just failed,
  // unless the other operand still occupies that port.
  always_comb begin
    fail0_p0 = fetching & need0_left & pend0_q & ~port0_op_q;
    fail0_p1 = fetching & need0_left & pend1_q & ~port1_op_q;
    fail1_p0 = fetching & need1_left & pend0_q &  port0_op_q;
    fail1_p1 = fetching & need1_left & pend1_q &  port1_op_q;
    sel0_d   = sel0_q;
    sel1_d   = sel1_q;
    if (fail0_p0 && !(need1_left && !sel1_q))
      sel0_d = 1'b1;
    else if (fail0_p1 && !(need1_left && sel1_q))
      sel0_d = 1'b0;
    if (fail1_p1 && !(need0_left && !sel0_q))
      sel1_d = 1'b1;
    else if (fail1_p0 && !(need0_left && sel0_q))
      sel1_d = 1'b0;
  end
`else
  always_comb begin
    sel0_d = 1'b0;
    sel1_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    instr_ready_o = 1'b0;
    alu_valid_o   = 1'b0;
    accept        = 1'b0;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          instr_ready_o = 1'b1;
          if (instr_valid_i) begin
            accept  = 1'b1;
            state_d = (instr_op0_used_i || instr_op1_used_i) ? S_FETCH : S_DONE;
          end
        end
        S_FETCH: begin
          if (fetch_done) state_d = S_DONE;
        end
        S_DONE: begin
          alu_valid_o = 1'b1;
          if (alu_ready_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op0_addr_q <= '0;
      op1_addr_q <= '0;
      dest_q     <= '0;
      data0_q    <= '0;
      data1_q    <= '0;
      need0_q    <= 1'b0;
      need1_q    <= 1'b0;
      pend0_q    <= 1'b0;
      pend1_q    <= 1'b0;
      port0_op_q <= 1'b0;
      port1_op_q <= 1'b0;
      sel0_q     <= 1'b0;
      sel1_q     <= 1'b0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else if (flush_i) begin
      need0_q   <= 1'b0;
      need1_q   <= 1'b0;
      pend0_q   <= 1'b0;
      pend1_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (accept) begin
        op0_addr_q <= instr_op0_addr_i;
        op1_addr_q <= instr_op1_addr_i;
        dest_q     <= instr_dest_addr_i;
        need0_q    <= instr_op0_used_i;
        need1_q    <= instr_op1_used_i;
        data0_q    <= '0;
        data1_q    <= '0;
        pend0_q    <= 1'b0;
        pend1_q    <= 1'b0;
        sel0_q     <= 1'b0;
        sel1_q     <= 1'b0;
        cnt_q      <= '0;
      end else if (fetching) begin
        pend0_q    <= req0_v;
        pend1_q    <= req1_v;
        port0_op_q <= p0_for_op1;
        port1_op_q <= ~p1_for_op0;
        need0_q    <= need0_left;
        need1_q    <= need1_left;
        sel0_q     <= sel0_d;
        sel1_q     <= sel1_d;
        if (cap0) data0_q <= cap0_data;
        if (cap1) data1_q <= cap1_data;
        // Saturating retry count; the pulse fires on the step into the limit.
        if (!fetch_done && cnt_q != RETRY_LIMIT) begin
          cnt_q     <= cnt_q + 1'b1;
          timeout_q <= (cnt_q == RETRY_LAST);
        end
      end else begin
        pend0_q <= 1'b0;
        pend1_q <= 1'b0;
      end
    end
  end

  assign alu_op0_o       = data0_q;
  assign alu_op1_o       = data1_q;
  assign alu_dest_addr_o = dest_q;
  assign fetch_timeout_o = timeout_q;

endmodule

// File: tb/tb_eu_operand_fetch.sv
// tb/tb_eu_operand_fetch.sv - scoreboard testbench for eu_operand_fetch

module tb_eu_operand_fetch;
  import eu_operand_fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n, flush_i, instr_valid_i, instr_ready_o;
  type_alu_local_addr instr_op0_addr_i, instr_op1_addr_i, instr_dest_addr_i;
  logic               instr_op0_used_i, instr_op1_used_i;
  logic               alu_valid_o, alu_ready_i, fetch_timeout_o;
  type_exec_unit_data alu_op0_o, alu_op1_o;
  type_alu_local_addr alu_dest_addr_o;

  eu_operand_fetch_if ybuf();

  eu_operand_fetch dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .flush_i          (flush_i),
    .instr_valid_i    (instr_valid_i),
    .instr_ready_o    (instr_ready_o),
    .instr_op0_addr_i (instr_op0_addr_i),
    .instr_op1_addr_i (instr_op1_addr_i),
    .instr_op0_used_i (instr_op0_used_i),
    .instr_op1_used_i (instr_op1_used_i),
    .instr_dest_addr_i(instr_dest_addr_i),
    .ybuf             (ybuf),
    .alu_valid_o      (alu_valid_o),
    .alu_ready_i      (alu_ready_i),
    .alu_op0_o        (alu_op0_o),
    .alu_op1_o        (alu_op1_o),
    .alu_dest_addr_o  (alu_dest_addr_o),
    .fetch_timeout_o  (fetch_timeout_o)
  );

  int checks = 0;
  int failures = 0;

  // Y-buffer contents and scripted per-address failure counts
  type_exec_unit_data mem [256];
  int                 fail_left [256];
  int                 ybuf_mode;   // 0 random, 1 scripted, 2 never succeed
  bit                 rand_rdy;
  logic               alu_rdy_dir;

  typedef struct {
    type_exec_unit_data op0;
    type_exec_unit_data op1;
    type_alu_local_addr dest;
  } exp_t;
  exp_t sb[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Y-buffer model: a request seen in cycle N is answered in cycle N+1.
  bit                 pv0, pv1;
  type_alu_local_addr pa0, pa1;

  always @(negedge clk) begin
    pv0 <= ybuf.op0_req_addr_valid_o;
    pv1 <= ybuf.op1_req_addr_valid_o;
    pa0 <= ybuf.op0_req_addr_o;
    pa1 <= ybuf.op1_req_addr_o;
  end

  task automatic respond(input bit pv, input type_alu_local_addr a,
                         output logic s, output type_exec_unit_data d);
    s = 1'b0;
    d = $urandom;
    if (pv) begin
      case (ybuf_mode)
        0: s = ($urandom_range(0, 2) != 0);
        1: begin
          if (fail_left[a] == 0) s = 1'b1;
          else fail_left[a] = fail_left[a] - 1;
        end
        default: s = 1'b0;
      endcase
      if (s) d = mem[a];
    end else if (ybuf_mode == 0) begin
      s = ($urandom_range(0, 3) == 0);   // spurious success must be ignored
    end
  endtask

  always begin
    logic               s0, s1;
    type_exec_unit_data d0, d1;
    @(posedge clk);
    #2;
    alu_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : alu_rdy_dir;
    respond(pv0, pa0, s0, d0);
    respond(pv1, pa1, s1, d1);
    ybuf.op0_data_i         = d0;
    ybuf.op0_data_success_i = s0;
    ybuf.op1_data_i         = d1;
    ybuf.op1_data_success_i = s1;
  end

  // Scoreboard: push on accepted instruction, pop on ALU handshake.
  always @(negedge clk) begin
    if (reset_n) begin
      if (instr_valid_i && instr_ready_o) begin
        exp_t e;
        e.op0  = instr_op0_used_i ? mem[instr_op0_addr_i] : '0;
        e.op1  = instr_op1_used_i ? mem[instr_op1_addr_i] : '0;
        e.dest = instr_dest_addr_i;
        sb.push_back(e);
      end
      if (alu_valid_o && alu_ready_i) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: actual=alu_valid with no pending instruction required=no output");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_op0", alu_op0_o, e.op0);
          chk("sb_op1", alu_op1_o, e.op1);
          chk("sb_dest", 32'(alu_dest_addr_o), 32'(e.dest));
        end
      end
    end
  end

  task automatic send(input type_alu_local_addr a0, input type_alu_local_addr a1,
                      input logic u0, input logic u1, input type_alu_local_addr d);
    bit got = 0;
    instr_op0_addr_i  = a0;
    instr_op1_addr_i  = a1;
    instr_op0_used_i  = u0;
    instr_op1_used_i  = u1;
    instr_dest_addr_i = d;
    instr_valid_i     = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (instr_ready_o) got = 1;
      @(posedge clk);
      #1;
    end
    instr_valid_i = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: actual=not accepted required=accepted within 200 cycles");
    end
  endtask

  // Count cycles from acceptance to alu_valid_o and requests per address.
  task automatic wait_valid(input type_alu_local_addr a0, input type_alu_local_addr a1,
                            output int lat, output int n0, output int n1);
    bit seen = 0;
    lat = 1; n0 = 0; n1 = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if ((ybuf.op0_req_addr_valid_o && ybuf.op0_req_addr_o == a0) ||
          (ybuf.op1_req_addr_valid_o && ybuf.op1_req_addr_o == a0)) n0++;
      if ((ybuf.op0_req_addr_valid_o && ybuf.op0_req_addr_o == a1) ||
          (ybuf.op1_req_addr_valid_o && ybuf.op1_req_addr_o == a1)) n1++;
      if (alu_valid_o) seen = 1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL valid_timeout: actual=no alu_valid required=alu_valid within 100 cycles");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n0, n1, tcount, tfirst;
    reset_n = 1'b0; flush_i = 1'b0; instr_valid_i = 1'b0;
    instr_op0_addr_i = '0; instr_op1_addr_i = '0; instr_dest_addr_i = '0;
    instr_op0_used_i = 1'b0; instr_op1_used_i = 1'b0;
    rand_rdy = 0; alu_rdy_dir = 1'b1; ybuf_mode = 1;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      fail_left[i] = 0;
    end
    mem[2] = 32'hA5; mem[3] = 32'h5A; mem[8'h10] = 32'h11;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_instr_ready", 32'(instr_ready_o), 32'd1);
    chk("rst_alu_valid", 32'(alu_valid_o), 32'd0);
    chk("rst_req0_valid", 32'(ybuf.op0_req_addr_valid_o), 32'd0);
    chk("rst_req1_valid", 32'(ybuf.op1_req_addr_valid_o), 32'd0);
    chk("rst_timeout", 32'(fetch_timeout_o), 32'd0);
    chk("rst_alu_op0", alu_op0_o, 32'd0);
    chk("rst_alu_op1", alu_op1_o, 32'd0);
    chk("rst_dest", 32'(alu_dest_addr_o), 32'd0);
    @(posedge clk); #1;

    // both operands hit on the first try
    send(8'd2, 8'd3, 1'b1, 1'b1, 8'h09);
    wait_valid(8'd2, 8'd3, lat, n0, n1);
    chk("hit_latency", 32'(lat), 32'd3);
    chk("hit_req_op0", 32'(n0), 32'd1);
    chk("hit_req_op1", 32'(n1), 32'd1);
    chk("hit_op0", alu_op0_o, 32'hA5);
    chk("hit_op1", alu_op1_o, 32'h5A);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hit_back_idle", 32'(instr_ready_o), 32'd1);
    chk("hit_valid_drop", 32'(alu_valid_o), 32'd0);
    @(posedge clk); #1;

    // op0 fails twice, op1 hits
    fail_left[8'h10] = 2;
    send(8'h10, 8'h11, 1'b1, 1'b1, 8'h12);
    wait_valid(8'h10, 8'h11, lat, n0, n1);
    chk("retry_latency", 32'(lat), 32'd5);
    chk("retry_req_op0", 32'(n0), 32'd3);
    chk("retry_req_op1", 32'(n1), 32'd1);
    chk("retry_op0", alu_op0_o, 32'h11);
    @(posedge clk); #1;

    // no operand used
    send(8'h20, 8'h21, 1'b0, 1'b0, 8'h22);
    wait_valid(8'h20, 8'h21, lat, n0, n1);
    chk("none_latency", 32'(lat), 32'd1);
    chk("none_reqs", 32'(n0 + n1), 32'd0);
    chk("none_op0", alu_op0_o, 32'd0);
    chk("none_op1", alu_op1_o, 32'd0);
    @(posedge clk); #1;

    // ALU stalls for 4 cycles in DONE
    alu_rdy_dir = 1'b0;
    send(8'h30, 8'h31, 1'b1, 1'b1, 8'h44);
    wait_valid(8'h30, 8'h31, lat, n0, n1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      instr_valid_i = 1'b1;
      instr_op0_addr_i = 8'h50; instr_op0_used_i = 1'b1;
      @(negedge clk);
      chk("stall_valid", 32'(alu_valid_o), 32'd1);
      chk("stall_op0", alu_op0_o, mem[8'h30]);
      chk("stall_op1", alu_op1_o, mem[8'h31]);
      chk("stall_dest", 32'(alu_dest_addr_o), 32'h44);
      chk("stall_not_ready", 32'(instr_ready_o), 32'd0);
    end
    @(posedge clk); #1;
    instr_valid_i = 1'b0;
    alu_rdy_dir = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_release", 32'(instr_ready_o), 32'd1);
    @(posedge clk); #1;

    // never succeeds: one timeout pulse, requests continue, then flush
    ybuf_mode = 2;
    tcount = 0; tfirst = 0;
    send(8'h06, 8'h07, 1'b1, 1'b1, 8'h66);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (fetch_timeout_o) begin
        tcount++;
        if (tfirst == 0) tfirst = c;
      end
      if (c == 40) begin
        chk("to_req0_continues", 32'(ybuf.op0_req_addr_valid_o), 32'd1);
        chk("to_req1_continues", 32'(ybuf.op1_req_addr_valid_o), 32'd1);
      end
      @(posedge clk); #1;
    end
    chk("to_pulse_count", 32'(tcount), 32'd1);
    chk("to_pulse_cycle", 32'(tfirst), 32'd16);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_req0", 32'(ybuf.op0_req_addr_valid_o), 32'd0);
    chk("flush_req1", 32'(ybuf.op1_req_addr_valid_o), 32'd0);
    chk("flush_idle", 32'(instr_ready_o), 32'd1);
    chk("flush_no_valid", 32'(alu_valid_o), 32'd0);
    sb.delete();
    ybuf_mode = 1;
    @(posedge clk); #1;

    // flush beats a simultaneous instruction in IDLE
    flush_i = 1'b1;
    instr_valid_i = 1'b1;
    instr_op0_used_i = 1'b1; instr_op1_used_i = 1'b1;
    @(negedge clk);
    chk("flush_blocks_ready", 32'(instr_ready_o), 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    instr_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_nothing_started",
          32'({alu_valid_o, ybuf.op0_req_addr_valid_o, ybuf.op1_req_addr_valid_o}), 32'd0);
      @(posedge clk); #1;
    end

`ifdef EU_FETCH_PORT_SWAP_EN
    // op1 done, op0 failing on port 0 moves to port 1
    fail_left[4] = 2;
    send(8'h04, 8'h05, 1'b1, 1'b1, 8'h77);
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("swap_req1_valid", 32'(ybuf.op1_req_addr_valid_o), 32'd1);
    chk("swap_req1_addr", 32'(ybuf.op1_req_addr_o), 32'h04);
    @(posedge clk); #1;
    wait_valid(8'h04, 8'h05, lat, n0, n1);
    chk("swap_op0", alu_op0_o, mem[4]);
    @(posedge clk); #1;
`endif

    // reset in the middle of a fetch
    ybuf_mode = 2;
    send(8'h08, 8'h09, 1'b1, 1'b1, 8'h55);
    repeat (3) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_dest", 32'(alu_dest_addr_o), 32'd0);
    chk("mid_rst_req0", 32'(ybuf.op0_req_addr_valid_o), 32'd0);
    chk("mid_rst_ready", 32'(instr_ready_o), 32'd1);
    chk("mid_rst_valid", 32'(alu_valid_o), 32'd0);
    sb.delete();
    ybuf_mode = 0;
    @(posedge clk); #1;

    // randomized traffic against the scoreboard
    rand_rdy = 1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)));
    end
    for (int k = 0; k < 500 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eu_operand_fetch.md
Name: eu_operand_fetch

Overview:
- Requester side of the execution-unit Y-buffer operand interface.
- Accepts one decoded instruction with up to two local operand addresses.
- Drives the op0/op1 request ports of the Y-buffer and retries each operand every cycle until a successful read is returned.
- Presents the gathered operand pair to the ALU through a valid/ready handshake.

Parameters:
- MAX_RETRY, 15, FETCH cycles without full completion before fetch_timeout_o pulses.
- CNT_BITS, 4, retry counter width; must hold MAX_RETRY.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset: synchronous, active-low
- flush_i  in  1  abort current instruction, return to IDLE
- instr_valid_i  in  1  instruction offered
- instr_ready_o  out  1  block can accept an instruction
- instr_op0_addr_i  in  $bits(type_alu_local_addr)  operand 0 local address
- instr_op1_addr_i  in  $bits(type_alu_local_addr)  operand 1 local address
- instr_op0_used_i  in  1  operand 0 must be fetched
- instr_op1_used_i  in  1  operand 1 must be fetched
- instr_dest_addr_i  in  $bits(type_alu_local_addr)  result address, passed through
- op0_req_addr_o  out  $bits(type_alu_local_addr)  Y-buffer port 0 request address
- op0_req_addr_valid_o  out  1  port 0 request valid
- op1_req_addr_o  out  $bits(type_alu_local_addr)  Y-buffer port 1 request address
- op1_req_addr_valid_o  out  1  port 1 request valid
- op0_data_i  in  $bits(type_exec_unit_data)  port 0 read data
- op0_data_success_i  in  1  port 0 read succeeded
- op1_data_i  in  $bits(type_exec_unit_data)  port 1 read data
- op1_data_success_i  in  1  port 1 read succeeded
- alu_valid_o  out  1  operands ready for ALU
- alu_ready_i  in  1  ALU accepts
- alu_op0_o  out  $bits(type_exec_unit_data)  operand 0 value (0 if unused)
- alu_op1_o  out  $bits(type_exec_unit_data)  operand 1 value (0 if unused)
- alu_dest_addr_o  out  $bits(type_alu_local_addr)  latched destination
- fetch_timeout_o  out  1  one-cycle pulse on retry limit

Behaviour:
- Reset values: state IDLE; instr_ready_o=1; all other outputs 0; need, pend and counter registers 0.
- IDLE:
  - instr_ready_o=1.
  - On instr_valid_i, latch both addresses and dest; set need0=op0_used, need1=op1_used; clear captured data.
  - If neither operand is used, go to DONE; otherwise go to FETCH.
- FETCH:
  - instr_ready_o=0.
  - Each cycle, drive opN_req_addr_valid_o=needN with the latched address.
  - Record pendN=reqN (issued this cycle) and the issuing port.
  - Read latency is 1 cycle: the response to a request issued in cycle N is sampled in cycle N+1.
  - A response counts only if pend was set and the operand is still needed. On success, capture the data and clear need.
  - Responses to requests for operands already captured are ignored. A redundant read is harmless.
  - When need0 and need1 are both clear, go to DONE.
- DONE:
  - alu_valid_o=1; data and dest held stable.
  - On alu_ready_i, go to IDLE; the next instruction is accepted no earlier than the following cycle.
- Minimum latency: accept in cycle 0, requests in cycle 1, capture in cycle 2, alu_valid_o in cycle 3.
- Retry counter:
  - Cleared on entry to FETCH; increments each FETCH cycle that does not complete.
  - When it equals MAX_RETRY, fetch_timeout_o pulses for 1 cycle and the counter saturates.
  - Fetching continues after the pulse; the block never gives up by itself.
- flush_i: highest priority after reset. From any state, next state is IDLE. Requests are deasserted next cycle, pend is cleared, alu_valid_o=0, and in-flight responses are dropped.
- Simultaneous instr_valid_i and flush_i in IDLE: the flush wins and the instruction is not accepted.
- Reset mid-operation behaves identically to flush and additionally restores the reset values.
- Operand ordering: both operands may succeed in the same cycle. Success on one and failure on the other means only the failing operand is retried.

Optional Feature:
- Macro: EU_FETCH_PORT_SWAP_EN.
- Defined: an operand whose response failed is reissued on the opposite port in the next cycle, provided that port is not needed by the other operand. The Y-buffer serves the two ports from alternating banks, so this reaches the other bank. A per-operand port-select bit is tracked, and responses are routed back by the recorded port.
- Undefined: fixed mapping, op0 on port 0 and op1 on port 1 only.

Test Plan:
- Both operands hit first try: op0 addr 2 returns 0xA5, op1 addr 3 returns 0x5A with success=1 in cycle 2 -> alu_valid_o in cycle 3, alu_op0_o=0xA5, alu_op1_o=0x5A; alu_ready_i=1 -> IDLE, instr_ready_o=1.
- op0 fails twice then succeeds with 0x11, op1 succeeds immediately -> op1 request stops after cycle 1. op0 request held for 3 cycles. alu_valid_o in cycle 5.
- Neither operand used -> no requests issued; alu_valid_o in cycle 1 with both operands 0.
- Success never asserted, MAX_RETRY=15 -> fetch_timeout_o high exactly once, 15 cycles into FETCH; requests continue. flush_i -> request valids 0 next cycle, state IDLE.
- alu_ready_i held 0 for 4 cycles in DONE -> outputs stable; instr_valid_i ignored (instr_ready_o=0).
- With EU_FETCH_PORT_SWAP_EN, op1 done and op0 fails on port 0 -> next cycle op1_req_addr_o=op0 addr; success there is captured into alu_op0_o.
